dt24_tx: RTL and testbench

Transmit end of the 24-bit source-synchronous pixel link (dt24). It accepts 24-bit pixels from the VisionTransformer datapath over a valid/ready stream and buffers them in a small FIFO. It drives them off-chip on the dt24 pads with a forwarded clock, a write strobe and per-pin output enables. It is instantiated next to the dt24 receive logic and owns the `dt24_*_o` / `dt24_*_oenb` pad signals.

---
 rtl/dt24_tx.sv | 256 +++++++++++++++++++++++++
 tb/tb_dt24_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt24_tx.sv
// dt24_tx: transmit end of the 24-bit source-synchronous pixel link (dt24).
// Latency: accepted push on an idle link -> beat on the pins after 1+2*CLK_DIV cycles; one beat per 2*CLK_DIV cycles.
// Backpressure: pix_ready_o is registered from the next FIFO count and drops only when the FIFO is full.
//
// Ports:
//   wb_clk_i, wb_rst_i          system clock, asynchronous active-high reset
//   pix_valid_i/_data_i/_last_i input pixel stream (RGB888 + end-of-frame flag)
//   pix_ready_o                 FIFO can accept a pixel
//   dt24_clk_o/_we_o/_data_o    forwarded link clock, beat strobe, beat data
//   dt24_*_oenb                 pad output enables, active-low, all driven from one flop
//   busy_o, frame_done_o        link not idle; one-cycle end-of-frame pulse
//
// Build option: define DT24_TX_CLKGATE_EN to park the forwarded clock low while
// the FIFO is empty mid-frame instead of sending we=0 bubble beats.
module dt24_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        pix_valid_i,
  input  logic [23:0] pix_data_i,
  input  logic        pix_last_i,
  output logic        pix_ready_o,
  output logic        dt24_clk_o,
  output logic        dt24_we_o,
  output logic [23:0] dt24_data_o,
  output logic        dt24_clk_oenb,
  output logic        dt24_we_oenb,
  output logic [23:0] dt24_data_oenb,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LEAD_MAX = LW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------- FIFO
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          push;
  logic          pop;
  logic [24:0]   head;

  assign push = pix_valid_i && pix_ready_o;
  assign head = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + 1'b1;
    end else if (!push && pop) begin
      count_n = count - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {pix_last_i, pix_data_i};
    end
  end

  // Pops are decided from the registered count, so a word pushed on one edge
  // is never popped before the next one.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pix_ready_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_n;
      pix_ready_o <= (count_n < DEPTH_C);
    end
  end

  // ---------------------------------------------------------------- link FSM
  typedef enum logic [1:0] {IDLE, LEAD, SEND, TAIL} state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_n;
  logic [LW-1:0] lead_cnt;
  logic [LW-1:0] lead_n;
  logic          clk_n;
  logic          we_n;
  logic [23:0]   data_n;
  logic          oenb_q;
  logic          oenb_n;
  logic          done_n;
  logic          last_q;     // last launched word closed the frame
  logic          last_n;
  logic          hold_q;     // forwarded clock parked low waiting for data
  logic          wrap;
  logic          fall;

`ifdef DT24_TX_CLKGATE_EN
  logic          hold_n;
`else
  assign hold_q = 1'b0;
`endif

  assign wrap = (div_cnt == DIV_MAX);
  // Fall point of the free-running clock: the half-period ends while high.
  assign fall = wrap && dt24_clk_o;

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    lead_n  = lead_cnt;
    clk_n   = dt24_clk_o;
    we_n    = dt24_we_o;
    data_n  = dt24_data_o;
    oenb_n  = oenb_q;
    done_n  = 1'b0;
    last_n  = last_q;
    pop     = 1'b0;
`ifdef DT24_TX_CLKGATE_EN
    hold_n  = hold_q;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = LEAD;
          oenb_n  = 1'b0;
          lead_n  = '0;
        end
      end
      LEAD: begin
        // Clock held low for a full link period so the receiver sees the
        // pads driven before the first rising edge.
        if (lead_cnt == LEAD_MAX) begin
          state_n = SEND;
          pop     = 1'b1;
          we_n    = 1'b1;
          data_n  = head[23:0];
          last_n  = head[24];
          div_n   = '0;
        end else begin
          lead_n = lead_cnt + 1'b1;
        end
      end
      SEND: begin
        if (hold_q) begin
          // Clock parked low: the first cycle with data is itself a fall
          // point, restart the half-period so setup is a full CLK_DIV.
          if (count != '0) begin
            pop    = 1'b1;
            we_n   = 1'b1;
            data_n = head[23:0];
            last_n = head[24];
            div_n  = '0;
`ifdef DT24_TX_CLKGATE_EN
            hold_n = 1'b0;
`endif
          end
        end else begin
          if (wrap) begin
            div_n = '0;
            clk_n = ~dt24_clk_o;
          end else begin
            div_n = div_cnt + 1'b1;
          end
          if (fall) begin
            if (last_q) begin
              state_n = TAIL;
              we_n    = 1'b0;
              last_n  = 1'b0;
            end else if (count != '0) begin
              pop    = 1'b1;
              we_n   = 1'b1;
              data_n = head[23:0];
              last_n = head[24];
            end else begin
              we_n = 1'b0;
`ifdef DT24_TX_CLKGATE_EN
              hold_n = 1'b1;
`endif
            end
          end
        end
      end
      TAIL: begin
        if (wrap) begin
          div_n = '0;
          clk_n = ~dt24_clk_o;
        end else begin
          div_n = div_cnt + 1'b1;
        end
        if (fall) begin
          state_n = IDLE;
          oenb_n  = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      div_cnt      <= '0;
      lead_cnt     <= '0;
      dt24_clk_o   <= 1'b0;
      dt24_we_o    <= 1'b0;
      dt24_data_o  <= '0;
      oenb_q       <= 1'b1;
      frame_done_o <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_n;
      lead_cnt     <= lead_n;
      dt24_clk_o   <= clk_n;
      dt24_we_o    <= we_n;
      dt24_data_o  <= data_n;
      oenb_q       <= oenb_n;
      frame_done_o <= done_n;
      last_q       <= last_n;
    end
  end

`ifdef DT24_TX_CLKGATE_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_n;
    end
  end
`endif

  assign busy_o         = (state != IDLE);
  assign dt24_clk_oenb  = oenb_q;
  assign dt24_we_oenb   = oenb_q;
  assign dt24_data_oenb = {24{oenb_q}};

endmodule

// File: tb/tb_dt24_tx.sv
module tb_dt24_tx;

  localparam int DEPTH = 8;
  localparam int DIV   = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        pix_valid_i;
  logic [23:0] pix_data_i;
  logic        pix_last_i;
  logic        pix_ready_o;
  logic        dt24_clk_o;
  logic        dt24_we_o;
  logic [23:0] dt24_data_o;
  logic        dt24_clk_oenb;
  logic        dt24_we_oenb;
  logic [23:0] dt24_data_oenb;
  logic        busy_o;
  logic        frame_done_o;

  int total = 0;
  int bad   = 0;

  dt24_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .pix_valid_i    (pix_valid_i),
    .pix_data_i     (pix_data_i),
    .pix_last_i     (pix_last_i),
    .pix_ready_o    (pix_ready_o),
    .dt24_clk_o     (dt24_clk_o),
    .dt24_we_o      (dt24_we_o),
    .dt24_data_o    (dt24_data_o),
    .dt24_clk_oenb  (dt24_clk_oenb),
    .dt24_we_oenb   (dt24_we_oenb),
    .dt24_data_oenb (dt24_data_oenb),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

  // Receiver model: latches beats on rising edges of the forwarded clock and
  // flags any data/we change while the link clock is high.
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          got_t[$];
  int          cyc      = 0;
  int          viol     = 0;
  int          done_cnt = 0;
  logic        p_clk    = 1'b0;
  logic        p_we     = 1'b0;
  logic [23:0] p_dat    = '0;

  always @(negedge wb_clk_i) begin
    cyc = cyc + 1;
    if (!wb_rst_i) begin
      if (((dt24_data_o !== p_dat) || (dt24_we_o !== p_we)) && (dt24_clk_o !== 1'b0)) viol = viol + 1;
      if (dt24_clk_o === 1'b1 && dt24_clk_oenb !== 1'b0) viol = viol + 1;
      if (p_clk === 1'b0 && dt24_clk_o === 1'b1 && dt24_we_o === 1'b1) begin
        got_q.push_back(dt24_data_o);
        got_t.push_back(cyc);
      end
      if (frame_done_o === 1'b1) done_cnt = done_cnt + 1;
    end
    p_clk = dt24_clk_o;
    p_we  = dt24_we_o;
    p_dat = dt24_data_o;
  end

  task automatic push_one(input logic [23:0] d, input logic l);
    int g;
    g = 0;
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    pix_last_i  = l;
    while (!pix_ready_o && g < 200) begin
      @(posedge wb_clk_i); #1;
      g++;
    end
    @(posedge wb_clk_i); #1;
    pix_valid_i = 1'b0;
    pix_last_i  = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic test_reset();
    logic [6:0] st;
    #3;
    st = {pix_ready_o, dt24_clk_o, dt24_we_o, busy_o, frame_done_o, dt24_clk_oenb, dt24_we_oenb};
    total++; if (st !== 7'b0000011) begin bad++; $display("FAIL reset_state got=%b want=%b", st, 7'b0000011); end
    total++; if (dt24_data_o !== 24'h0 || dt24_data_oenb !== 24'hFFFFFF) begin bad++; $display("FAIL reset_data got=%h/%h want=000000/ffffff", dt24_data_o, dt24_data_oenb); end
    @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
    total++; if (pix_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_held got=%b want=0", pix_ready_o); end
    #2 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    total++; if (pix_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_before_edge got=%b want=0", pix_ready_o); end
    @(negedge wb_clk_i);
    total++; if (pix_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after_edge got=%b want=1", pix_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_single();
    int d, k_send, k_tail, k_idle;
    logic exp_clk;
    logic [4:0] exp_st, got_st;
    exp_q.delete(); got_q.delete(); got_t.delete();
    viol = 0; d = done_cnt;
    k_send = 1 + 2 * DIV;
    k_tail = k_send + 2 * DIV;
    k_idle = k_tail + 2 * DIV;
    @(posedge wb_clk_i); #1;
    total++; if (pix_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", pix_ready_o); end
    pix_valid_i = 1'b1; pix_data_i = 24'hABCDEF; pix_last_i = 1'b1;
    @(posedge wb_clk_i); #1;
    exp_q.push_back(24'hABCDEF);
    pix_valid_i = 1'b0; pix_last_i = 1'b0;
    for (int k = 0; k <= k_idle + 1; k++) begin
      @(negedge wb_clk_i);
      exp_clk = (k >= k_send && k < k_idle) ? (((k - k_send) / DIV) % 2 == 1) : 1'b0;
      exp_st  = {((k >= 1 && k < k_idle) ? 1'b0 : 1'b1), exp_clk, (k >= k_send && k < k_tail),
                 (k == k_idle), (k >= 1 && k < k_idle)};
      got_st  = {dt24_clk_oenb, dt24_clk_o, dt24_we_o, frame_done_o, busy_o};
      total++; if (got_st !== exp_st) begin bad++; $display("FAIL single_pins edge=%0d got oenb,clk,we,done,busy=%b want=%b", k, got_st, exp_st); end
      total++; if (dt24_data_oenb !== {24{exp_st[4]}} || dt24_we_oenb !== exp_st[4]) begin bad++; $display("FAIL single_oenb edge=%0d got=%h/%b want all %b", k, dt24_data_oenb, dt24_we_oenb, exp_st[4]); end
      if (k >= k_send) begin
        total++; if (dt24_data_o !== 24'hABCDEF) begin bad++; $display("FAIL single_data edge=%0d got=%h want=abcdef", k, dt24_data_o); end
      end
    end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_beats got=%0d want=1", got_q.size()); end
    else begin total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL single_beat_val got=%h want=%h", got_q[0], exp_q[0]); end end
    total++; if (done_cnt !== d + 1) begin bad++; $display("FAIL single_done got=%0d want=%0d", done_cnt - d, 1); end
    total++; if (viol !== 0) begin bad++; $display("FAIL single_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_burst();
    int i, guard, d;
    logic rdy, saw_full;
    exp_q.delete(); got_q.delete(); got_t.delete();
    viol = 0; d = done_cnt; i = 0; guard = 0; saw_full = 1'b0;
    pix_valid_i = 1'b1; pix_data_i = 24'd1; pix_last_i = 1'b0;
    while (i < 12 && guard < 400) begin
      rdy = pix_ready_o;
      @(posedge wb_clk_i); #1;
      guard++;
      if (rdy) begin
        exp_q.push_back(pix_data_i);
        i++;
        pix_data_i = 24'(i + 1);
        pix_last_i = (i == 11);
      end else begin
        saw_full = 1'b1;
      end
    end
    pix_valid_i = 1'b0; pix_last_i = 1'b0;
    for (guard = 0; guard < 1000 && done_cnt == d; guard++) @(negedge wb_clk_i);
    total++; if (done_cnt !== d + 1) begin bad++; $display("FAIL burst_done got=%0d want=1", done_cnt - d); end
    total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL burst_ready_drop got=%b want=1", saw_full); end
    total++; if (got_q.size() !== 12) begin bad++; $display("FAIL burst_beats got=%0d want=12", got_q.size()); end
    for (int j = 0; j < 12 && j < got_q.size(); j++) begin
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL burst_val idx=%0d got=%h want=%h", j, got_q[j], exp_q[j]); end
    end
    for (int j = 1; j < got_t.size(); j++) begin
      total++; if (got_t[j] - got_t[j-1] !== 2 * DIV) begin bad++; $display("FAIL burst_spacing idx=%0d got=%0d want=%0d", j, got_t[j] - got_t[j-1], 2 * DIV); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL burst_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_bubble();
    int d, rises, launch_c, rise_c, exp_rises, guard;
    logic pc;
    exp_q.delete(); got_q.delete(); got_t.delete();
    viol = 0; d = done_cnt;
    push_one(24'd1, 1'b0);
    push_one(24'd2, 1'b0);
    repeat (13) @(negedge wb_clk_i);
    pc = dt24_clk_o;
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk_i);
      total++; if (dt24_we_o !== 1'b0 || dt24_data_o !== 24'd2) begin bad++; $display("FAIL bubble_hold k=%0d got we=%b data=%h want we=0 data=000002", k, dt24_we_o, dt24_data_o); end
      if (pc === 1'b0 && dt24_clk_o === 1'b1) rises++;
      pc = dt24_clk_o;
    end
`ifdef DT24_TX_CLKGATE_EN
    exp_rises = 0;
`else
    exp_rises = 8 / (2 * DIV);
`endif
    total++; if (rises !== exp_rises) begin bad++; $display("FAIL bubble_clk_rises got=%0d want=%0d", rises, exp_rises); end
    push_one(24'd3, 1'b1);
    launch_c = -1; rise_c = -1; pc = dt24_clk_o;
    for (int k = 0; k < 60 && rise_c < 0; k++) begin
      @(negedge wb_clk_i);
      if (launch_c < 0 && dt24_we_o === 1'b1 && dt24_data_o === 24'd3) launch_c = k;
      else if (launch_c >= 0 && pc === 1'b0 && dt24_clk_o === 1'b1) rise_c = k;
      pc = dt24_clk_o;
    end
    total++; if (launch_c < 0 || rise_c - launch_c !== DIV) begin bad++; $display("FAIL bubble_rise_after_launch got launch=%0d rise=%0d want gap=%0d", launch_c, rise_c, DIV); end
    for (guard = 0; guard < 500 && done_cnt == d; guard++) @(negedge wb_clk_i);
    total++; if (got_q.size() !== 3) begin bad++; $display("FAIL bubble_beats got=%0d want=3", got_q.size()); end
    for (int j = 0; j < 3 && j < got_q.size(); j++) begin
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL bubble_val idx=%0d got=%h want=%h", j, got_q[j], exp_q[j]); end
    end
    total++; if (done_cnt !== d + 1) begin bad++; $display("FAIL bubble_done got=%0d want=1", done_cnt - d); end
    total++; if (viol !== 0) begin bad++; $display("FAIL bubble_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_random();
    int d, nfr, len, gap, guard;
    logic [23:0] v;
    exp_q.delete(); got_q.delete(); got_t.delete();
    viol = 0; d = done_cnt; nfr = 5;
    for (int f = 0; f < nfr; f++) begin
      len = $urandom_range(1, 10);
      for (int p = 0; p < len; p++) begin
        v = 24'($urandom);
        push_one(v, p == len - 1);
        gap = $urandom_range(0, 6);
        repeat (gap) @(posedge wb_clk_i);
        #1;
      end
    end
    for (guard = 0; guard < 4000 && done_cnt < d + nfr; guard++) @(negedge wb_clk_i);
    total++; if (done_cnt !== d + nfr) begin bad++; $display("FAIL random_done got=%0d want=%0d", done_cnt - d, nfr); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL random_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL random_val idx=%0d got=%h want=%h", j, got_q[j], exp_q[j]); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL random_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid();
    int d, guard;
    logic [6:0] st;
    exp_q.delete(); got_q.delete(); got_t.delete();
    viol = 0; d = done_cnt;
    for (int i = 0; i < 6; i++) push_one(24'h100000 + 24'(i), i == 5);
    for (guard = 0; guard < 300 && got_q.size() < 3; guard++) @(negedge wb_clk_i);
    total++; if (got_q.size() !== 3 || busy_o !== 1'b1) begin bad++; $display("FAIL rmid_progress got beats=%0d busy=%b want 3/1", got_q.size(), busy_o); end
    #2 wb_rst_i = 1'b1;
    #1;
    st = {pix_ready_o, dt24_clk_o, dt24_we_o, busy_o, frame_done_o, dt24_clk_oenb, dt24_we_oenb};
    total++; if (st !== 7'b0000011) begin bad++; $display("FAIL rmid_async_state got=%b want=%b", st, 7'b0000011); end
    total++; if (dt24_data_o !== 24'h0 || dt24_data_oenb !== 24'hFFFFFF) begin bad++; $display("FAIL rmid_async_data got=%h/%h want=000000/ffffff", dt24_data_o, dt24_data_oenb); end
    @(posedge wb_clk_i); @(posedge wb_clk_i); #3;
    wb_rst_i = 1'b0;
    exp_q.delete(); got_q.delete(); got_t.delete();
    repeat (5) @(negedge wb_clk_i);
    total++; if (busy_o !== 1'b0 || dt24_clk_oenb !== 1'b1) begin bad++; $display("FAIL rmid_fifo_flushed got busy=%b oenb=%b want 0/1", busy_o, dt24_clk_oenb); end
    total++; if (done_cnt !== d) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", done_cnt - d); end
    push_one(24'h5A5A5A, 1'b1);
    for (guard = 0; guard < 300 && done_cnt == d; guard++) @(negedge wb_clk_i);
    total++; if (done_cnt !== d + 1) begin bad++; $display("FAIL rmid_new_done got=%0d want=1", done_cnt - d); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rmid_new_beats got=%0d want=1", got_q.size()); end
    else begin total++; if (got_q[0] !== 24'h5A5A5A) begin bad++; $display("FAIL rmid_new_val got=%h want=5a5a5a", got_q[0]); end end
    total++; if (viol !== 0) begin bad++; $display("FAIL rmid_protocol got=%0d want=0", viol); end
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    pix_valid_i = 1'b0;
    pix_data_i  = '0;
    pix_last_i  = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_bubble();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
